// File: rtl/data_memory_ctrl_pkg.sv
// Shared types for the data-memory endpoint: request opcodes, controller FSM states, default timing.
`ifndef D_MEMORY_ADDR_WIDTH
`define D_MEMORY_ADDR_WIDTH 32
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif

package data_memory_ctrl_pkg;

    typedef enum logic [1:0] {
        mem_nop   = 2'b00,
        mem_read  = 2'b01,
        mem_write = 2'b10
    } memory_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RESPOND = 2'b10
    } dmem_state_t;

    localparam int DMEM_DEFAULT_LATENCY = 2;
    localparam logic [7:0] DMEM_LFSR_SEED = 8'hA5;

endpackage

// File: rtl/dmem_latency_lfsr.sv
// 8-bit Fibonacci LFSR (x^8+x^6+x^5+x^4+1) that steps once per accepted access.
// Drives the per-access latency jitter of data_memory_ctrl.
module dmem_latency_lfsr
    import data_memory_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       advance,
    output logic [7:0] lfsr
);

    logic feedback;

    assign feedback = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lfsr <= DMEM_LFSR_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[6:0], feedback};
        end
    end

endmodule

// File: rtl/data_memory_ctrl.sv
// Single-outstanding data-memory endpoint: accepts one load/store, waits LATENCY cycles, acks once.
// Optional feature macro DMEM_RAND_LATENCY_EN randomises the per-access latency to 1..LATENCY.
module data_memory_ctrl
    import data_memory_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = DMEM_DEFAULT_LATENCY,
    parameter int ADDR_W  = `D_MEMORY_ADDR_WIDTH,
    parameter int DATA_W  = `REG_VAL_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memory_req_valid,
    input  memory_op_t        memory_req_op,
    input  logic [ADDR_W-1:0] memory_req_address,
    input  logic [DATA_W-1:0] memory_req_data,
    output logic              memory_ready,
    output logic              memory_ack,
    output logic [DATA_W-1:0] memory_data_return
);

    localparam int IDX_W = $clog2(DEPTH);

    dmem_state_t       state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic [3:0]        lat_load;
    logic              accept;
    memory_op_t        cap_op;
    logic [IDX_W-1:0]  cap_idx;
    logic [DATA_W-1:0] cap_data;
    logic [DATA_W-1:0] mem [DEPTH];

    // Byte-lane bits and bits above the array size are deliberately dropped (round down, wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memory_req_address[1:0], memory_req_address[ADDR_W-1:IDX_W+2]};

`ifdef DMEM_RAND_LATENCY_EN
    logic [7:0] lfsr;
    logic       unused_lfsr_hi;

    dmem_latency_lfsr u_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (accept),
        .lfsr    (lfsr)
    );

    // Latency uses the pre-step LFSR value; the step happens on the same accepting edge.
    assign lat_load       = 4'(1 + (32'(lfsr[3:0]) % LATENCY));
    assign unused_lfsr_hi = ^lfsr[7:4];
`else
    assign lat_load = 4'(LATENCY);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_op   <= mem_nop;
            cap_idx  <= '0;
            cap_data <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_op   <= memory_req_op;
                cap_idx  <= memory_req_address[IDX_W+1:2];
                cap_data <= memory_req_data;
            end
        end
    end

    always_comb begin
        state_nxt          = state;
        cnt_nxt            = cnt;
        accept             = 1'b0;
        memory_ready       = 1'b0;
        memory_ack         = 1'b0;
        memory_data_return = '0;
        case (state)
            IDLE: begin
                memory_ready = 1'b1;
                if (memory_req_valid &&
                    (memory_req_op == mem_read || memory_req_op == mem_write)) begin
                    accept    = 1'b1;
                    state_nxt = BUSY;
                    cnt_nxt   = lat_load;
                end
            end
            BUSY: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                memory_ack = 1'b1;
                if (cap_op == mem_read) begin
                    memory_data_return = mem[cap_idx];
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Store commits at the end of RESPOND so a following load always sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == RESPOND && cap_op == mem_write) begin
            mem[cap_idx] <= cap_data;
        end
    end

endmodule
